// File: rtl/param_shift_reg.sv
// WIDTH-bit universal register (load/shift/rotate/clear) with a multi-cycle shift-by-N sequencer.
// Define PARITY_OUT_EN to add a registered parity output (XOR of Q).
module param_shift_reg #(
    parameter int unsigned      WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    parameter int unsigned      AMT_W     = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] D,
    input  logic             sin,
    input  logic             start,
    input  logic [AMT_W-1:0] amt,
    output logic [WIDTH-1:0] Q,
    output logic             sout,
    output logic             busy,
    output logic             done
`ifdef PARITY_OUT_EN
    ,
    output logic             parity
`endif
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIN
    } state_t;

    typedef enum logic [2:0] {
        M_HOLD = 3'b000,
        M_LOAD = 3'b001,
        M_SHL  = 3'b010,
        M_SHR  = 3'b011,
        M_ROL  = 3'b100,
        M_ROR  = 3'b101,
        M_ASR  = 3'b110,
        M_CLR  = 3'b111
    } mode_t;

    localparam logic [AMT_W-1:0] AMT_MAX = AMT_W'(WIDTH);
    localparam logic [AMT_W-1:0] AMT_ONE = AMT_W'(1);

    state_t           state, state_n;
    mode_t            mode_r, mode_r_n;
    mode_t            op;
    logic [AMT_W-1:0] cnt, cnt_n;
    logic [AMT_W-1:0] amt_sat;
    logic [WIDTH-1:0] q_n;
    logic             sout_n;
    logic [WIDTH-1:0] step_q;
    logic             step_sout;
    logic             seq_mode;

    assign amt_sat  = (amt > AMT_MAX) ? AMT_MAX : amt;
    assign seq_mode = (mode != M_HOLD) && (mode != M_LOAD) && (mode != M_CLR);
    // While running, the latched mode drives the datapath; live mode is ignored.
    assign op = (state == RUN) ? mode_r : mode_t'(mode);

    always_comb begin
        step_q    = Q;
        step_sout = sout;
        case (op)
            M_HOLD: ;
            M_LOAD: step_q = D;
            M_SHL: begin
                step_q    = {Q[WIDTH-2:0], sin};
                step_sout = Q[WIDTH-1];
            end
            M_SHR: begin
                step_q    = {sin, Q[WIDTH-1:1]};
                step_sout = Q[0];
            end
            M_ROL:  step_q = {Q[WIDTH-2:0], Q[WIDTH-1]};
            M_ROR:  step_q = {Q[0], Q[WIDTH-1:1]};
            M_ASR: begin
                step_q    = {Q[WIDTH-1], Q[WIDTH-1:1]};
                step_sout = Q[0];
            end
            M_CLR:  step_q = RESET_VAL;
            default: ;
        endcase
    end

    always_comb begin
        state_n  = state;
        mode_r_n = mode_r;
        cnt_n    = cnt;
        q_n      = Q;
        sout_n   = sout;
        case (state)
            IDLE: begin
                if (start && seq_mode) begin
                    mode_r_n = mode_t'(mode);
                    if (amt_sat == '0) begin
                        state_n = FIN;
                    end else begin
                        q_n    = step_q;
                        sout_n = step_sout;
                        if (amt_sat == AMT_ONE) begin
                            state_n = FIN;
                        end else begin
                            state_n = RUN;
                            cnt_n   = amt_sat - AMT_ONE;
                        end
                    end
                end else begin
                    q_n    = step_q;
                    sout_n = step_sout;
                end
            end
            RUN: begin
                q_n    = step_q;
                sout_n = step_sout;
                cnt_n  = cnt - AMT_ONE;
                if (cnt == AMT_ONE) begin
                    state_n = FIN;
                end
            end
            FIN: begin
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // busy/done are registered from the next state so they line up with the state flops.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            mode_r <= M_HOLD;
            cnt    <= '0;
            Q      <= RESET_VAL;
            sout   <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else if (en) begin
            state  <= state_n;
            mode_r <= mode_r_n;
            cnt    <= cnt_n;
            Q      <= q_n;
            sout   <= sout_n;
            busy   <= (state_n != IDLE);
            done   <= (state_n == FIN);
        end
    end

`ifdef PARITY_OUT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            parity <= ^RESET_VAL;
        end else if (en) begin
            parity <= ^q_n;
        end
    end
`endif

endmodule

// File: tb/tb_param_shift_reg.sv
// Directed self-checking bench for param_shift_reg (WIDTH=8, RESET_VAL=0).
// Also exercises the parity output when built with PARITY_OUT_EN.
module tb_param_shift_reg;

    logic       clk;
    logic       reset;
    logic       en;
    logic [2:0] mode;
    logic [7:0] D;
    logic       sin;
    logic       start;
    logic [3:0] amt;
    logic [7:0] Q;
    logic       sout;
    logic       busy;
    logic       done;
`ifdef PARITY_OUT_EN
    logic       parity;
`endif

    int checks   = 0;
    int failures = 0;

    param_shift_reg #(
        .WIDTH(8),
        .RESET_VAL(8'h00)
    ) dut (
        .clk(clk),
        .reset(reset),
        .en(en),
        .mode(mode),
        .D(D),
        .sin(sin),
        .start(start),
        .amt(amt),
        .Q(Q),
        .sout(sout),
        .busy(busy),
        .done(done)
`ifdef PARITY_OUT_EN
        ,
        .parity(parity)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; en = 1'b0; mode = 3'b000; D = 8'h00;
        sin = 1'b0; start = 1'b0; amt = 4'd0;
        repeat (2) tick();
        checks++; if (Q !== 8'h00) begin failures++; $display("FAIL reset_q got=%h exp=00", Q); end
        checks++; if (sout !== 1'b0) begin failures++; $display("FAIL reset_sout got=%b exp=0", sout); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_shift();
        en = 1'b1;
        mode = 3'b001; D = 8'hA5; tick();
        checks++; if (Q !== 8'hA5) begin failures++; $display("FAIL load_a5 got=%h exp=a5", Q); end
        mode = 3'b010; sin = 1'b1; tick();
        checks++; if (Q !== 8'h4B) begin failures++; $display("FAIL shl_q got=%h exp=4b", Q); end
        checks++; if (sout !== 1'b1) begin failures++; $display("FAIL shl_sout got=%b exp=1", sout); end
        mode = 3'b011; sin = 1'b0; tick();
        checks++; if (Q !== 8'h25) begin failures++; $display("FAIL shr_q got=%h exp=25", Q); end
        checks++; if (sout !== 1'b1) begin failures++; $display("FAIL shr_sout got=%b exp=1", sout); end
        mode = 3'b000; D = 8'hFF; tick();
        checks++; if (Q !== 8'h25) begin failures++; $display("FAIL hold_q got=%h exp=25", Q); end
    endtask

    task automatic test_rotate();
        mode = 3'b001; D = 8'h81; tick();
        mode = 3'b100; tick();
        checks++; if (Q !== 8'h03) begin failures++; $display("FAIL rol_q got=%h exp=03", Q); end
        mode = 3'b101; tick();
        checks++; if (Q !== 8'h81) begin failures++; $display("FAIL ror1_q got=%h exp=81", Q); end
        tick();
        checks++; if (Q !== 8'hC0) begin failures++; $display("FAIL ror2_q got=%h exp=c0", Q); end
        checks++; if (sout !== 1'b1) begin failures++; $display("FAIL rot_keeps_sout got=%b exp=1", sout); end
        mode = 3'b001; D = 8'h80; tick();
        mode = 3'b110; tick();
        checks++; if (Q !== 8'hC0) begin failures++; $display("FAIL asr_q got=%h exp=c0", Q); end
        checks++; if (sout !== 1'b0) begin failures++; $display("FAIL asr_sout got=%b exp=0", sout); end
        mode = 3'b111; tick();
        checks++; if (Q !== 8'h00) begin failures++; $display("FAIL clr_q got=%h exp=00", Q); end
        mode = 3'b000;
    endtask

    task automatic test_sequence();
        mode = 3'b001; D = 8'h01; tick();
        mode = 3'b010; start = 1'b1; amt = 4'd3; sin = 1'b0; tick();
        checks++; if (Q !== 8'h02 || busy !== 1'b1 || done !== 1'b0) begin
            failures++; $display("FAIL seq_step1 got=%h/%b/%b exp=02/1/0", Q, busy, done); end
        start = 1'b0; mode = 3'b001; D = 8'hFF; tick();
        checks++; if (Q !== 8'h04 || busy !== 1'b1 || done !== 1'b0) begin
            failures++; $display("FAIL seq_step2 got=%h/%b/%b exp=04/1/0", Q, busy, done); end
        tick();
        checks++; if (Q !== 8'h08 || busy !== 1'b1 || done !== 1'b1) begin
            failures++; $display("FAIL seq_step3 got=%h/%b/%b exp=08/1/1", Q, busy, done); end
        mode = 3'b000; tick();
        checks++; if (Q !== 8'h08 || busy !== 1'b0 || done !== 1'b0) begin
            failures++; $display("FAIL seq_idle got=%h/%b/%b exp=08/0/0", Q, busy, done); end
    endtask

    task automatic test_amt_zero();
        mode = 3'b010; start = 1'b1; amt = 4'd0; sin = 1'b1; tick();
        checks++; if (Q !== 8'h08 || busy !== 1'b1 || done !== 1'b1) begin
            failures++; $display("FAIL amt0_fin got=%h/%b/%b exp=08/1/1", Q, busy, done); end
        start = 1'b0; mode = 3'b000; tick();
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin
            failures++; $display("FAIL amt0_idle got=%b/%b exp=0/0", busy, done); end
    endtask

    task automatic test_saturate();
        int n;
        mode = 3'b010; start = 1'b1; amt = 4'd12; sin = 1'b0; tick();
        checks++; if (Q !== 8'h10 || busy !== 1'b1) begin
            failures++; $display("FAIL sat_step1 got=%h/%b exp=10/1", Q, busy); end
        start = 1'b0; mode = 3'b000;
        n = 0;
        while (done !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        checks++; if (n !== 7) begin failures++; $display("FAIL sat_cycles got=%0d exp=7", n); end
        checks++; if (Q !== 8'h00) begin failures++; $display("FAIL sat_q got=%h exp=00", Q); end
        tick();
    endtask

    task automatic test_stall();
        mode = 3'b001; D = 8'h01; tick();
        mode = 3'b010; start = 1'b1; amt = 4'd4; sin = 1'b1; tick();
        start = 1'b0; mode = 3'b000; tick();
        checks++; if (Q !== 8'h07) begin failures++; $display("FAIL stall_pre got=%h exp=07", Q); end
        en = 1'b0; tick(); tick();
        checks++; if (Q !== 8'h07 || busy !== 1'b1 || done !== 1'b0) begin
            failures++; $display("FAIL stall_hold got=%h/%b/%b exp=07/1/0", Q, busy, done); end
        en = 1'b1; tick();
        checks++; if (Q !== 8'h0F || done !== 1'b0) begin
            failures++; $display("FAIL stall_step3 got=%h/%b exp=0f/0", Q, done); end
        tick();
        checks++; if (Q !== 8'h1F || done !== 1'b1) begin
            failures++; $display("FAIL stall_fin got=%h/%b exp=1f/1", Q, done); end
        en = 1'b0; tick();
        checks++; if (Q !== 8'h1F || done !== 1'b1 || busy !== 1'b1) begin
            failures++; $display("FAIL stall_in_fin got=%h/%b/%b exp=1f/1/1", Q, done, busy); end
        en = 1'b1; tick();
        checks++; if (done !== 1'b0 || busy !== 1'b0) begin
            failures++; $display("FAIL stall_idle got=%b/%b exp=0/0", done, busy); end
    endtask

    task automatic test_start_nonseq();
        mode = 3'b001; start = 1'b1; D = 8'h3C; amt = 4'd5; tick();
        checks++; if (Q !== 8'h3C || busy !== 1'b0 || done !== 1'b0) begin
            failures++; $display("FAIL start_load got=%h/%b/%b exp=3c/0/0", Q, busy, done); end
        start = 1'b0; mode = 3'b000; tick();
    endtask

    task automatic test_reset_mid_run();
        mode = 3'b001; D = 8'h01; tick();
        mode = 3'b010; start = 1'b1; amt = 4'd5; sin = 1'b0; tick();
        start = 1'b0; mode = 3'b000; tick();
        checks++; if (Q !== 8'h04 || busy !== 1'b1) begin
            failures++; $display("FAIL mid_run got=%h/%b exp=04/1", Q, busy); end
        #2 reset = 1'b1;
        #1;
        checks++; if (Q !== 8'h00 || busy !== 1'b0 || done !== 1'b0 || sout !== 1'b0) begin
            failures++; $display("FAIL async_reset got=%h/%b/%b/%b exp=00/0/0/0", Q, busy, done, sout); end
        #2 reset = 1'b0;
        mode = 3'b010; start = 1'b1; amt = 4'd1; sin = 1'b1; tick();
        checks++; if (Q !== 8'h01 || busy !== 1'b1 || done !== 1'b1) begin
            failures++; $display("FAIL restart got=%h/%b/%b exp=01/1/1", Q, busy, done); end
        start = 1'b0; mode = 3'b000; tick();
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin
            failures++; $display("FAIL restart_idle got=%b/%b exp=0/0", busy, done); end
    endtask

`ifdef PARITY_OUT_EN
    task automatic test_parity();
        mode = 3'b001; D = 8'h07; tick();
        checks++; if (parity !== 1'b1) begin failures++; $display("FAIL parity_07 got=%b exp=1", parity); end
        D = 8'h03; tick();
        checks++; if (parity !== 1'b0) begin failures++; $display("FAIL parity_03 got=%b exp=0", parity); end
        mode = 3'b000;
    endtask
`endif

    initial begin
        test_reset();
        test_shift();
        test_rotate();
        test_sequence();
        test_amt_zero();
        test_saturate();
        test_stall();
        test_start_nonseq();
        test_reset_mid_run();
`ifdef PARITY_OUT_EN
        test_parity();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
